ram_sdp_be: RTL and testbench

//  Parametrised simple-dual-port synchronous RAM: one write port with byte enables, one read port.

---
 rtl/ram_pkg.sv | 9 +
 rtl/ram_sdp_core.sv | 33 +++
 rtl/ram_sdp_be.sv | 64 ++++++
 tb/tb_ram_sdp_be.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared read-during-write constants, init FSM encoding and byte-enable width helper
package ram_pkg;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  typedef enum logic {ST_INIT, ST_READY} state_t;
  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/ram_sdp_core.sv
// ram_sdp_core: bare byte-enable array with a registered read port and read-during-write mux
module ram_sdp_core
  import ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int RDW_MODE = RDW_OLD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);
  localparam int BW = be_w(DATA_W);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rword;
  always_ff @(posedge clk)
    for (int i = 0; i < BW; i++)
      if (we && wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  always_comb begin
    rword = mem[raddr];
    for (int i = 0; i < BW; i++)
      rword[8*i +: 8] = (RDW_MODE == RDW_NEW && we && waddr == raddr && wbe[i]) ? wdata[8*i +: 8] : rword[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= rword;
endmodule

// File: rtl/ram_sdp_be.sv
// ram_sdp_be: simple-dual-port byte-enable RAM with post-reset zero-fill and 1/2-cycle read latency
module ram_sdp_be
  import ram_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = RDW_OLD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                init_busy
);
  if (DATA_W % 8 != 0) begin : g_bad_dw
    $error("DATA_W must be a multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_rl
    $error("READ_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
    $error("RDW_MODE must be 0 or 1");
  end
  state_t state, state_nx;
  logic [ADDR_W-1:0]   cnt, waddr;
  logic [DATA_W-1:0]   wdata, d1, d2;
  logic [DATA_W/8-1:0] wbe;
  logic                ready, we, re, v1, v2;
  assign ready     = state == ST_READY;
  assign init_busy = !ready;
  assign we        = ready ? wr_en : 1'b1;
  assign waddr     = ready ? wr_addr : cnt;
  assign wdata     = ready ? wr_data : '0;
  assign wbe       = ready ? wr_be : '1;
  assign re        = ready && rd_en;
  assign rd_data   = READ_LATENCY == 2 ? d2 : d1;
  assign rd_valid  = READ_LATENCY == 2 ? v2 : v1;
  always_comb state_nx = (state == ST_INIT && &cnt) ? ST_READY : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      d2    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= ready ? cnt : cnt + 1'b1;
      v1    <= re;
      v2    <= v1;
      if (v1) d2 <= d1;
    end
  ram_sdp_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RDW_MODE(RDW_MODE)) u_core (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(rd_addr), .rdata(d1)
  );
endmodule

// File: tb/tb_ram_sdp_be.sv
// tb_ram_sdp_be: two configurations (latency1/old-data, latency2/new-data) against an array-and-queue model
module tb_ram_sdp_be;
  localparam int DEPTH = 1024;
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [9:0] wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0] wr_be = '0;
  logic [31:0] rd_data_a, rd_data_b;
  logic rd_valid_a, rd_valid_b, init_busy_a, init_busy_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ram_sdp_be dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .init_busy(init_busy_a)
  );
  ram_sdp_be #(.READ_LATENCY(2), .RDW_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .init_busy(init_busy_b)
  );
  logic [31:0] mem [DEPTH];
  logic [31:0] old, last_a = '0, last_b = '0;
  int sweep = DEPTH, cyc = 0;
  int qa_due[$], qb_due[$];
  logic [31:0] qa_d[$], qb_d[$];
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      qa_due.delete(); qb_due.delete(); qa_d.delete(); qb_d.delete();
      last_a = '0; last_b = '0; sweep = DEPTH;
    end else if (sweep > 0) begin
      sweep--;
    end else begin
      old = mem[rd_addr];
      if (rd_en) begin
        qa_due.push_back(cyc);     qa_d.push_back(old);
        qb_due.push_back(cyc + 1); qb_d.push_back((wr_en && wr_addr == rd_addr) ? merge(old, wr_data, wr_be) : old);
      end
      if (wr_en) mem[wr_addr] = merge(mem[wr_addr], wr_data, wr_be);
    end
  end
  always @(posedge clk) begin
    logic ea, eb;
    #3;
    chk("busy_a", init_busy_a, !rst_n || sweep > 0);
    chk("busy_b", init_busy_b, !rst_n || sweep > 0);
    ea = qa_due.size() > 0 && qa_due[0] == cyc;
    eb = qb_due.size() > 0 && qb_due[0] == cyc;
    chk("valid_a", rd_valid_a, ea);
    chk("valid_b", rd_valid_b, eb);
    if (ea) begin last_a = qa_d.pop_front(); qa_due.delete(0); end
    if (eb) begin last_b = qb_d.pop_front(); qb_due.delete(0); end
    chk("data_a", rd_data_a, last_a);
    chk("data_b", rd_data_b, last_b);
  end
  task automatic step(input logic we, input logic [9:0] wa, input logic [31:0] wd, input logic [3:0] be,
                      input logic re, input logic [9:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; rd_en = re; rd_addr = ra;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask
  task automatic read_lit(input string name, input logic [9:0] ra, input logic [31:0] ea, input logic [31:0] eb,
                          input logic we, input logic [31:0] wd, input logic [3:0] be);
    step(we, ra, wd, be, 1'b1, ra);
    chk({name, "_va"}, rd_valid_a, 1'b1);
    chk({name, "_da"}, rd_data_a, ea);
    chk({name, "_vb_early"}, rd_valid_b, 1'b0);
    @(negedge clk);
    chk({name, "_vb"}, rd_valid_b, 1'b1);
    chk({name, "_db"}, rd_data_b, eb);
    chk({name, "_va_done"}, rd_valid_a, 1'b0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {init_busy_b, init_busy_a}, 2'b11);
    chk("rst_valid", {rd_valid_b, rd_valid_a}, 2'b00);
    chk("rst_data", rd_data_a | rd_data_b, 32'h0);
    rst_n = 1'b1;
    step(1'b1, 10'h010, 32'h12345678, 4'hF, 1'b1, 10'h010);
    repeat (DEPTH - 2) @(negedge clk);
    chk("sweep_busy_last", init_busy_a, 1'b1);
    @(negedge clk);
    chk("sweep_done", init_busy_a, 1'b0);
    read_lit("zero_31d", 10'h31D, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0);
    read_lit("init_drop", 10'h010, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0);
    step(1'b1, 10'h3FD, 32'hDEADBEEF, 4'hF, 1'b0, 10'h0);
    step(1'b1, 10'h3FD, 32'h11223344, 4'b0101, 1'b0, 10'h0);
    read_lit("byte_en", 10'h3FD, 32'hDE22BE44, 32'hDE22BE44, 1'b0, 32'h0, 4'h0);
    step(1'b1, 10'h39D, 32'hAAAAAAAA, 4'hF, 1'b0, 10'h0);
    read_lit("collide", 10'h39D, 32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h55555555, 4'hF);
    read_lit("after_collide", 10'h39D, 32'h55555555, 32'h55555555, 1'b0, 32'h0, 4'h0);
    step(1'b1, 10'h000, 32'h0A0A0A0A, 4'hF, 1'b0, 10'h0);
    step(1'b1, 10'h001, 32'h1B1B1B1B, 4'hF, 1'b0, 10'h0);
    step(1'b1, 10'h002, 32'h2C2C2C2C, 4'hF, 1'b0, 10'h0);
    rd_en = 1'b1; rd_addr = 10'h000;
    @(negedge clk); rd_addr = 10'h001;
    chk("lat2_a0", rd_data_a, 32'h0A0A0A0A);
    chk("lat2_b_idle", rd_valid_b, 1'b0);
    @(negedge clk); rd_addr = 10'h002;
    chk("lat2_b0", {rd_valid_b, rd_data_b}, {1'b1, 32'h0A0A0A0A});
    @(negedge clk); rd_en = 1'b0;
    chk("lat2_b1", {rd_valid_b, rd_data_b}, {1'b1, 32'h1B1B1B1B});
    @(negedge clk);
    chk("lat2_b2", {rd_valid_b, rd_data_b}, {1'b1, 32'h2C2C2C2C});
    @(negedge clk);
    chk("lat2_hold", {rd_valid_b, rd_data_b}, {1'b0, 32'h2C2C2C2C});
    repeat (3000) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 7));
      wr_data = $urandom;
      wr_be   = 4'($urandom_range(0, 15));
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 7));
      @(negedge clk);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    step(1'b1, 10'h3FD, 32'hCAFEF00D, 4'hF, 1'b0, 10'h0);
    step(1'b0, 10'h0, 32'h0, 4'h0, 1'b1, 10'h3FD);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {rd_valid_b, rd_valid_a}, 2'b00);
    chk("midrst_data", rd_data_a | rd_data_b, 32'h0);
    chk("midrst_busy", {init_busy_b, init_busy_a}, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DEPTH) @(negedge clk);
    chk("resweep_done", {init_busy_b, init_busy_a}, 2'b00);
    read_lit("resweep_3fd", 10'h3FD, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
